// File: rtl/game_fill_ctrl.sv
// game_fill_ctrl: sequences rectangle fills and single-pixel writes onto one game RAM write port; optional clipping via GAME_FILL_CLIP_EN
module game_fill_ctrl #(
  parameter int RAM_W = 160,
  parameter int RAM_H = 144,
  parameter int COORD_W = 10,
  parameter logic [COORD_W-1:0] PARK_ROW = 10'h3FF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_row,
  input  logic [COORD_W-1:0] cmd_col,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [11:0]        cmd_rgb,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_row,
  input  logic [COORD_W-1:0] pix_col,
  input  logic [11:0]        pix_rgb,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] cpu_row_position,
  output logic [COORD_W-1:0] cpu_col_position,
  output logic [11:0]        cpu_rgb_value
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  if (RAM_H > PARK_ROW || RAM_W >= 2**COORD_W) begin : g_bad_cfg
    $error("game_fill_ctrl: PARK_ROW must lie outside the RAM and RAM_W must fit in COORD_W");
  end
  state_t state;
  logic rdy;
  logic [COORD_W-1:0] base_row, base_col, w_q, h_q, c_off, r_off, eff_w, eff_h, nc, nr;
  logic [11:0] fill_rgb;
  logic last_c, last_r, pix_ok;
  assign cmd_ready = rdy;
  // fill wins the port: a pixel is only offered while no fill is requested
  assign pix_ready = rdy & ~cmd_valid;
`ifdef GAME_FILL_CLIP_EN
  localparam logic [COORD_W:0] RW = (COORD_W+1)'(RAM_W);
  localparam logic [COORD_W:0] RH = (COORD_W+1)'(RAM_H);
  logic [COORD_W:0] rem_c, rem_r;
  always_comb begin
    rem_c = ({1'b0, cmd_col} >= RW) ? '0 : RW - {1'b0, cmd_col};
    rem_r = ({1'b0, cmd_row} >= RH) ? '0 : RH - {1'b0, cmd_row};
    eff_w = ({1'b0, cmd_w} < rem_c) ? cmd_w : rem_c[COORD_W-1:0];
    eff_h = ({1'b0, cmd_h} < rem_r) ? cmd_h : rem_r[COORD_W-1:0];
    pix_ok = ({1'b0, pix_col} < RW) && ({1'b0, pix_row} < RH);
  end
`else
  always_comb begin
    eff_w = cmd_w;
    eff_h = cmd_h;
    pix_ok = 1'b1;
  end
`endif
  // end tests carry one extra bit so offset+1 never wraps against the size
  always_comb begin
    last_c = ({1'b0, c_off} + 1'b1) == {1'b0, w_q};
    last_r = ({1'b0, r_off} + 1'b1) == {1'b0, h_q};
    nc = last_c ? '0 : c_off + 1'b1;
    nr = last_c ? r_off + 1'b1 : r_off;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      rdy <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cpu_row_position <= PARK_ROW;
      cpu_col_position <= '0;
      cpu_rgb_value <= '0;
      base_row <= '0;
      base_col <= '0;
      w_q <= '0;
      h_q <= '0;
      c_off <= '0;
      r_off <= '0;
      fill_rgb <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          rdy <= 1'b1;
          cpu_row_position <= PARK_ROW;
          if (cmd_valid && rdy) begin
            base_row <= cmd_row;
            base_col <= cmd_col;
            w_q <= eff_w;
            h_q <= eff_h;
            fill_rgb <= cmd_rgb;
            c_off <= '0;
            r_off <= '0;
            rdy <= 1'b0;
            if (eff_w == '0 || eff_h == '0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= FILL;
              busy <= 1'b1;
              cpu_row_position <= cmd_row;
              cpu_col_position <= cmd_col;
              cpu_rgb_value <= cmd_rgb;
            end
          end else if (pix_valid && pix_ready) begin
            cpu_row_position <= pix_ok ? pix_row : PARK_ROW;
            cpu_col_position <= pix_col;
            cpu_rgb_value <= pix_rgb;
          end
        end
        FILL: begin
          if (last_c && last_r) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            cpu_row_position <= PARK_ROW;
          end else begin
            c_off <= nc;
            r_off <= nr;
            cpu_row_position <= base_row + nr;
            cpu_col_position <= base_col + nc;
            cpu_rgb_value <= fill_rgb;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          rdy <= 1'b1;
          cpu_row_position <= PARK_ROW;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_fill_ctrl.sv
// tb_game_fill_ctrl: directed self-checking bench for game_fill_ctrl
module tb_game_fill_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, pix_valid = 1'b0;
  logic [9:0] cmd_row = '0, cmd_col = '0, cmd_w = '0, cmd_h = '0, pix_row = '0, pix_col = '0;
  logic [11:0] cmd_rgb = '0, pix_rgb = '0;
  logic cmd_ready, pix_ready, busy, done;
  logic [9:0] row, col;
  logic [11:0] rgb;
  int checks = 0, errors = 0;
`ifdef GAME_FILL_CLIP_EN
  localparam int EDGE_N = 2;
`else
  localparam int EDGE_N = 5;
`endif
  game_fill_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_rgb(cmd_rgb),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_rgb(pix_rgb),
    .busy(busy), .done(done),
    .cpu_row_position(row), .cpu_col_position(col), .cpu_rgb_value(rgb)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [9:0] r, input logic [9:0] c, input logic [9:0] w, input logic [9:0] h, input logic [11:0] v);
    cmd_row = r; cmd_col = c; cmd_w = w; cmd_h = h; cmd_rgb = v; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask
  initial begin
    repeat (3) step();
    chk("rst_row", row, 10'h3FF);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    step();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_pix_ready", pix_ready, 1);
    fill(2, 3, 4, 2, 12'hF00);
    cmd_row = 10'd50; cmd_rgb = 12'h0AB;
    for (int i = 0; i < 8; i++) begin
      chk("fill_row", row, 2 + i / 4);
      chk("fill_col", col, 3 + i % 4);
      chk("fill_rgb", rgb, 12'hF00);
      chk("fill_busy", busy, 1);
      chk("fill_ready", cmd_ready, 0);
      step();
    end
    chk("fill_done", done, 1);
    chk("fill_done_busy", busy, 0);
    chk("fill_done_park", row, 10'h3FF);
    chk("fill_done_ready", cmd_ready, 0);
    step();
    chk("fill_idle_done", done, 0);
    chk("fill_idle_park", row, 10'h3FF);
    chk("fill_idle_ready", cmd_ready, 1);
    pix_row = 5; pix_col = 7; pix_rgb = 12'h0F0; pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    chk("pix_row", row, 5);
    chk("pix_col", col, 7);
    chk("pix_rgb", rgb, 12'h0F0);
    step();
    chk("pix_park", row, 10'h3FF);
    pix_row = 9; pix_col = 9; pix_rgb = 12'hABC; pix_valid = 1'b1;
    cmd_row = 1; cmd_col = 1; cmd_w = 2; cmd_h = 1; cmd_rgb = 12'h00F; cmd_valid = 1'b1;
    #1;
    chk("prio_pix_ready", pix_ready, 0);
    step();
    cmd_valid = 1'b0;
    chk("prio_w0_row", row, 1);
    chk("prio_w0_col", col, 1);
    chk("prio_w0_rgb", rgb, 12'h00F);
    chk("prio_fill_pix_ready", pix_ready, 0);
    step();
    chk("prio_w1_col", col, 2);
    chk("prio_w1_rgb", rgb, 12'h00F);
    step();
    chk("prio_done", done, 1);
    chk("prio_done_pix_ready", pix_ready, 0);
    step();
    chk("prio_idle_pix_ready", pix_ready, 1);
    chk("prio_idle_park", row, 10'h3FF);
    step();
    pix_valid = 1'b0;
    chk("prio_pix_row", row, 9);
    chk("prio_pix_col", col, 9);
    chk("prio_pix_rgb", rgb, 12'hABC);
    step();
    chk("prio_pix_park", row, 10'h3FF);
    fill(4, 4, 0, 5, 12'h555);
    chk("zero_done", done, 1);
    chk("zero_park", row, 10'h3FF);
    chk("zero_busy", busy, 0);
    step();
    chk("zero_idle_done", done, 0);
    chk("zero_idle_ready", cmd_ready, 1);
    fill(0, 158, 5, 1, 12'h777);
    for (int i = 0; i < EDGE_N; i++) begin
      chk("edge_row", row, 0);
      chk("edge_col", col, 158 + i);
      step();
    end
    chk("edge_done", done, 1);
    chk("edge_park", row, 10'h3FF);
    step();
    chk("edge_idle_done", done, 0);
    fill(2, 3, 4, 2, 12'hF00);
    step();
    step();
    chk("abort_third_col", col, 5);
    chk("abort_third_row", row, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_park", row, 10'h3FF);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready_low", cmd_ready, 0);
    step();
    chk("abort_ready", cmd_ready, 1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_no_write", row, 10'h3FF);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
